// File: rtl/mem_wb_skid_pkg.sv
// Shared definitions for the MEM/WB skid-buffered pipeline register.
//   WB_DATA_W / WB_ADDR_W : default per-lane data and register-address widths
//   occ_e                 : occupancy encodings, also used as the FSM state
//   RST_ACTIVE            : level of rst that holds the block in reset
package mem_wb_skid_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/wb_lane_sanitize.sv
// Combinational clean-up of one writeback beat before it is stored.
//   data_i / addr_i / en_i : raw lanes from the memory stage (lane i at [i*W +: W])
//   data_o / addr_o / en_o : sanitised lanes
// A lane survives only if it is enabled, does not target x0, and no
// higher-index lane in the same beat writes the same register (the later
// instruction in program order wins). Lanes that do not survive are zeroed.
module wb_lane_sanitize
  import mem_wb_skid_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int LANES  = 1
) (
  input  logic [LANES*DATA_W-1:0] data_i,
  input  logic [LANES*ADDR_W-1:0] addr_i,
  input  logic [LANES-1:0]        en_i,
  output logic [LANES*DATA_W-1:0] data_o,
  output logic [LANES*ADDR_W-1:0] addr_o,
  output logic [LANES-1:0]        en_o
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [ADDR_W-1:0] lane_addr;
    logic              overwritten;
    logic              keep;

    assign lane_addr = addr_i[gi*ADDR_W +: ADDR_W];

    // Any enabled later lane with the same address supersedes this one.
    always_comb begin
      overwritten = 1'b0;
      for (int j = gi + 1; j < LANES; j++) begin
        if (en_i[j] && (addr_i[j*ADDR_W +: ADDR_W] == lane_addr)) begin
          overwritten = 1'b1;
        end
      end
    end

    assign keep = en_i[gi] && (lane_addr != '0) && !overwritten;

    assign en_o[gi]                   = keep;
    assign addr_o[gi*ADDR_W +: ADDR_W] = keep ? lane_addr : '0;
    assign data_o[gi*DATA_W +: DATA_W] = keep ? data_i[gi*DATA_W +: DATA_W] : '0;
  end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a 2-entry skid buffer and valid/ready handshake.
//   clk, rst (async, active-low), flush (sync)
//   in_valid/in_ready, in_rd_data/addr/enable : beat from the memory stage
//   out_valid/out_ready, wb_rd_data/addr/enable : beat to the register file
//   occupancy : number of held beats (0..2)
// in_ready comes straight from a flop, so out_ready never reaches it
// combinationally; the skid entry absorbs the beat accepted in the cycle
// where the consumer stalls.
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_rd_data,
  input  logic [LANES*ADDR_W-1:0] in_rd_addr,
  input  logic [LANES-1:0]        in_rd_enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] wb_rd_data,
  output logic [LANES*ADDR_W-1:0] wb_rd_addr,
  output logic [LANES-1:0]        wb_rd_enable,
  output logic [1:0]              occupancy
);

  localparam int DW = LANES * DATA_W;
  localparam int AW = LANES * ADDR_W;

  logic [DW-1:0]    san_data;
  logic [AW-1:0]    san_addr;
  logic [LANES-1:0] san_en;

  wb_lane_sanitize #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_sanitize (
    .data_i (in_rd_data),
    .addr_i (in_rd_addr),
    .en_i   (in_rd_enable),
    .data_o (san_data),
    .addr_o (san_addr),
    .en_o   (san_en)
  );

  occ_e             occ_q, occ_d;
  logic             in_ready_q, in_ready_d;
  logic [DW-1:0]    main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [AW-1:0]    main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
  logic [LANES-1:0] main_en_q, main_en_d, skid_en_q, skid_en_d;

  logic accept;
  logic drain;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;

  always_comb begin
    occ_d       = occ_q;
    main_data_d = main_data_q;
    main_addr_d = main_addr_q;
    main_en_d   = main_en_q;
    skid_data_d = skid_data_q;
    skid_addr_d = skid_addr_q;
    skid_en_d   = skid_en_q;

    if (flush) begin
      // Any beat offered this cycle is dropped; a coincident drain has
      // already been seen by the register file through wb_*.
      occ_d       = OCC_EMPTY;
      main_data_d = '0;
      main_addr_d = '0;
      main_en_d   = '0;
      skid_data_d = '0;
      skid_addr_d = '0;
      skid_en_d   = '0;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_data_d = san_data;
            main_addr_d = san_addr;
            main_en_d   = san_en;
            occ_d       = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            main_data_d = san_data;
            main_addr_d = san_addr;
            main_en_d   = san_en;
          end else if (accept) begin
            skid_data_d = san_data;
            skid_addr_d = san_addr;
            skid_en_d   = san_en;
            occ_d       = OCC_FULL;
          end else if (drain) begin
            main_data_d = '0;
            main_addr_d = '0;
            main_en_d   = '0;
            occ_d       = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only a drain can move the state.
          if (drain) begin
            main_data_d = skid_data_q;
            main_addr_d = skid_addr_q;
            main_en_d   = skid_en_q;
            skid_data_d = '0;
            skid_addr_d = '0;
            skid_en_d   = '0;
            occ_d       = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end

    in_ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      occ_q       <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_addr_q <= '0;
      main_en_q   <= '0;
      skid_data_q <= '0;
      skid_addr_q <= '0;
      skid_en_q   <= '0;
    end else begin
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_addr_q <= main_addr_d;
      main_en_q   <= main_en_d;
      skid_data_q <= skid_data_d;
      skid_addr_q <= skid_addr_d;
      skid_en_q   <= skid_en_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign occupancy    = occ_q;
  assign wb_rd_data   = out_valid ? main_data_q : '0;
  assign wb_rd_addr   = out_valid ? main_addr_q : '0;
  assign wb_rd_enable = out_valid ? main_en_q   : '0;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Self-checking bench for mem_wb_skid (3 lanes). Stimulus issues beats; a
// negedge monitor keeps a queue of expected beats and compares the outputs.
module tb_mem_wb_skid;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LANES  = 3;
  localparam int DW     = LANES * DATA_W;
  localparam int AW     = LANES * ADDR_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_rd_data = '0;
  logic [AW-1:0] in_rd_addr = '0;
  logic [LANES-1:0] in_rd_enable = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] wb_rd_data;
  logic [AW-1:0] wb_rd_addr;
  logic [LANES-1:0] wb_rd_enable;
  logic [1:0]    occupancy;

  mem_wb_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd_data   (in_rd_data),
    .in_rd_addr   (in_rd_addr),
    .in_rd_enable (in_rd_enable),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .wb_rd_data   (wb_rd_data),
    .wb_rd_addr   (wb_rd_addr),
    .wb_rd_enable (wb_rd_enable),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    d;
    logic [AW-1:0]    a;
    logic [LANES-1:0] e;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: walk lanes from last to first; the last writer of a register
  // claims it, x0 is never written, and unclaimed lanes read as zero.
  function automatic beat_t model(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                  input logic [LANES-1:0] e);
    beat_t r;
    bit    claimed [32];
    int    ad;
    r.d = '0;
    r.a = '0;
    r.e = '0;
    for (int k = 0; k < 32; k++) claimed[k] = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      ad = int'(a[i*ADDR_W +: ADDR_W]);
      if (e[i] && ad != 0 && !claimed[ad]) begin
        claimed[ad] = 1'b1;
        r.e[i] = 1'b1;
        r.a[i*ADDR_W +: ADDR_W] = a[i*ADDR_W +: ADDR_W];
        r.d[i*DATA_W +: DATA_W] = d[i*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  // Monitor / scoreboard: check the current state, then advance the model
  // by what the coming edge will do.
  always @(negedge clk) begin
    int    sz;
    beat_t hd;
    if (!rst) begin
      exp_q.delete();
      chk("rst in_ready", 128'(in_ready), 128'(1));
      chk("rst out_valid", 128'(out_valid), 128'(0));
      chk("rst occupancy", 128'(occupancy), 128'(0));
      chk("rst wb_bus", 128'({wb_rd_enable, wb_rd_addr}), 128'(0));
      chk("rst wb_data", 128'(wb_rd_data), 128'(0));
    end else begin
      sz = exp_q.size();
      chk("occupancy", 128'(occupancy), 128'(sz));
      chk("in_ready", 128'(in_ready), 128'(sz < 2));
      chk("out_valid", 128'(out_valid), 128'(sz > 0));
      if (out_valid && sz > 0) begin
        hd = exp_q[0];
        chk("wb_rd_enable", 128'(wb_rd_enable), 128'(hd.e));
        chk("wb_rd_addr", 128'(wb_rd_addr), 128'(hd.a));
        chk("wb_rd_data", 128'(wb_rd_data), 128'(hd.d));
      end else if (!out_valid) begin
        chk("bubble wb_bus", 128'({wb_rd_enable, wb_rd_addr}), 128'(0));
        chk("bubble wb_data", 128'(wb_rd_data), 128'(0));
      end
      if (out_valid && out_ready && sz > 0) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_rd_data, in_rd_addr, in_rd_enable));
    end
  end

  bit hold_beat = 1'b0;

  task automatic step();
    @(negedge clk);
    hold_beat = in_valid && !in_ready && !flush;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int ln, input logic [ADDR_W-1:0] ad,
                          input logic [DATA_W-1:0] dt, input logic en);
    in_rd_addr[ln*ADDR_W +: ADDR_W] = ad;
    in_rd_data[ln*DATA_W +: DATA_W] = dt;
    in_rd_enable[ln]                = en;
  endtask

  task automatic one_lane_beat(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dt);
    in_valid = 1'b1;
    set_lane(0, ad, dt, 1'b1);
    set_lane(1, '0, '0, 1'b0);
    set_lane(2, '0, '0, 1'b0);
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b1;
    step();

    // Basic pass-through.
    out_ready = 1'b1;
    one_lane_beat(5'd5, 32'hDEADBEEF);
    step();
    in_valid = 1'b0;
    chk("pass out_valid", 128'(out_valid), 128'(1));
    chk("pass addr", 128'(wb_rd_addr[ADDR_W-1:0]), 128'(5));
    chk("pass data", 128'(wb_rd_data[DATA_W-1:0]), 128'(32'hDEADBEEF));
    chk("pass enable", 128'(wb_rd_enable), 128'(3'b001));
    chk("pass occupancy", 128'(occupancy), 128'(1));
    step();

    // Backpressure fill, then ordered drain.
    out_ready = 1'b0;
    one_lane_beat(5'd1, 32'hA);
    step();
    one_lane_beat(5'd2, 32'hB);
    step();
    in_valid = 1'b0;
    chk("fill occupancy", 128'(occupancy), 128'(2));
    chk("fill in_ready", 128'(in_ready), 128'(0));
    chk("fill head addr", 128'(wb_rd_addr[ADDR_W-1:0]), 128'(1));
    out_ready = 1'b1;
    step();
    chk("drain1 head addr", 128'(wb_rd_addr[ADDR_W-1:0]), 128'(2));
    chk("drain1 in_ready", 128'(in_ready), 128'(1));
    chk("drain1 occupancy", 128'(occupancy), 128'(1));
    step();
    chk("drain2 occupancy", 128'(occupancy), 128'(0));

    // x0 suppression.
    one_lane_beat(5'd0, 32'h1234);
    step();
    in_valid = 1'b0;
    chk("x0 out_valid", 128'(out_valid), 128'(1));
    chk("x0 bus", 128'({wb_rd_enable, wb_rd_addr, wb_rd_data}), 128'(0));
    step();

    // Same-beat conflict: lane1 beats lane0.
    in_valid = 1'b1;
    set_lane(0, 5'd7, 32'd11, 1'b1);
    set_lane(1, 5'd7, 32'd22, 1'b1);
    set_lane(2, 5'd0, 32'd33, 1'b0);
    step();
    in_valid = 1'b0;
    chk("conflict enable", 128'(wb_rd_enable), 128'(3'b010));
    chk("conflict lane1 data", 128'(wb_rd_data[DATA_W +: DATA_W]), 128'(22));
    chk("conflict lane0", 128'({wb_rd_addr[ADDR_W-1:0], wb_rd_data[DATA_W-1:0]}), 128'(0));
    step();

    // Flush while full with a beat on offer.
    out_ready = 1'b0;
    one_lane_beat(5'd3, 32'h33);
    step();
    one_lane_beat(5'd4, 32'h44);
    step();
    chk("pre-flush occupancy", 128'(occupancy), 128'(2));
    flush = 1'b1;
    one_lane_beat(5'd9, 32'h99);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush occupancy", 128'(occupancy), 128'(0));
    chk("flush out_valid", 128'(out_valid), 128'(0));
    chk("flush in_ready", 128'(in_ready), 128'(1));
    chk("flush wb", 128'({wb_rd_enable, wb_rd_addr, wb_rd_data}), 128'(0));
    out_ready = 1'b1;
    step();
    chk("post-flush out_valid", 128'(out_valid), 128'(0));

    // Asynchronous reset between edges.
    out_ready = 1'b0;
    one_lane_beat(5'd6, 32'h66);
    step();
    in_valid = 1'b0;
    chk("pre-reset out_valid", 128'(out_valid), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("async out_valid", 128'(out_valid), 128'(0));
    chk("async enable", 128'(wb_rd_enable), 128'(0));
    chk("async occupancy", 128'(occupancy), 128'(0));
    step();
    rst = 1'b1;
    step();

    // Randomised traffic; small address range provokes x0 and conflicts.
    for (int c = 0; c < 2000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      if (!hold_beat) begin
        in_valid = ($urandom_range(0, 2) != 0);
        for (int l = 0; l < LANES; l++)
          set_lane(l, 5'($urandom_range(0, 3)), $urandom, 1'($urandom));
      end
      step();
    end

    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("scoreboard empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
- Parametrised MEM/WB pipeline register for the next core generation.
- Carries LANES independent writeback lanes from the memory stage to the register file, with a valid/ready handshake instead of a global stall vector.
- A 2-entry skid buffer keeps in_ready registered, so no combinational path runs from out_ready to in_ready.
- Also provides a synchronous flush, x0 write suppression and same-beat write-conflict resolution.

Parameters:
- DATA_W, 32: width of one lane's rd data.
- ADDR_W, 5: width of one lane's rd register address.
- LANES, 1: number of writeback lanes per beat (1..4); lane i occupies bits [i*W +: W] of each packed bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  memory stage presents a beat.
- in_ready  out  1  block can accept a beat; registered.
- in_rd_data  in  LANES*DATA_W  per-lane write data.
- in_rd_addr  in  LANES*ADDR_W  per-lane destination register.
- in_rd_enable  in  LANES  per-lane write request.
- out_valid  out  1  beat presented to writeback.
- out_ready  in  1  writeback consumes beat.
- wb_rd_data  out  LANES*DATA_W  per-lane data to register file.
- wb_rd_addr  out  LANES*ADDR_W  per-lane address to register file.
- wb_rd_enable  out  LANES  per-lane write strobe; qualified by out_valid.
- occupancy  out  2  number of held beats (0..2).

Behaviour:
- Reset (rst=0, asynchronous): both entries invalid.
  - in_ready=1, out_valid=0, occupancy=0.
  - wb_rd_data, wb_rd_addr and wb_rd_enable are all 0.
  - Reset mid-operation drops held beats immediately, without waiting for a clock edge.
- Handshakes:
  - Accept occurs on a clock edge where in_valid & in_ready.
  - Drain occurs on a clock edge where out_valid & out_ready.
  - Data is latched only on accept; in_* is don't-care when in_valid=0.
- State machine (occupancy):
  - EMPTY(0):
    - accept -> ONE; the beat goes into the main register.
  - ONE(1):
    - accept & drain -> ONE; main is reloaded with the new beat.
    - accept & !drain -> FULL; the new beat goes into the skid register.
    - drain & !accept -> EMPTY.
  - FULL(2):
    - in_ready=0, so no accept.
    - drain -> ONE; skid moves to main and skid is cleared.
- Latency:
  - A beat accepted into EMPTY appears on wb_* the next cycle.
  - Throughput is 1 beat/cycle when out_ready stays at 1.
- in_ready is registered.
  - It equals (next occupancy < 2), computed at the clock edge.
  - Consequence: after FULL->ONE, in_ready rises one cycle after the drain.
- Output qualification:
  - When out_valid=0, wb_rd_enable=0, wb_rd_data=0 and wb_rd_addr=0 (bubble).
  - When out_valid=1, wb_* reflect the main register.
- Lane sanitisation, applied at accept and stored already sanitised:
  - x0 suppression: a lane with addr==0 has its enable forced to 0.
  - Same-beat conflict: if lanes i<j both have enable=1 and the same nonzero addr, lane i's enable is cleared. The highest-index lane wins (program order).
  - Disabled lanes store data=0 and addr=0.
- Flush (synchronous):
  - Next state is EMPTY, with in_ready=1 and out_valid=0.
  - Flush has priority over a simultaneous accept or drain; the beat offered that cycle is discarded.
  - A drain coincident with flush still completes. The register file writes that cycle because wb_* is combinationally valid before the edge.
- Width rules:
  - No arithmetic; data passes bit-exact.
  - occupancy never exceeds 2; an attempt to accept in FULL is impossible by construction.
  - in_valid with in_ready=0 is held by the producer.

Decomposition:
- Shared package/config header:
  - WB_DATA_W and WB_ADDR_W defaults.
  - OCC_EMPTY/OCC_ONE/OCC_FULL encodings (2'd0/1/2).
  - The reset-active-low constant.
- One sub-module, wb_lane_sanitize (combinational): per-beat x0 suppression and conflict resolution across LANES. It is instantiated once on the input path.
- The skid/state logic stays in mem_wb_skid.

Test Plan:
- Reset/basic pass-through:
  - Stimulus: LANES=1; rst low for 3 cycles, then in_valid=1 with addr=5, data=32'hDEADBEEF, en=1; out_ready=1.
  - Response: one cycle later out_valid=1, wb_rd_addr=5, wb_rd_data=DEADBEEF, wb_rd_enable=1, occupancy=1.
- Backpressure fill:
  - Stimulus: out_ready=0; beats A(addr 1) and B(addr 2) sent back-to-back.
  - Response: occupancy=2, in_ready=0, wb shows A.
  - Then out_ready=1 for 2 cycles: A, then B drain in order; in_ready returns to 1 one cycle after the first drain.
- x0 suppression:
  - Stimulus: in addr=0, en=1, data=32'h1234.
  - Response: out_valid=1, wb_rd_enable=0, wb_rd_addr=0, wb_rd_data=0.
- Lane conflict:
  - Stimulus: LANES=2; lane0 {addr 7, data 11, en 1}, lane1 {addr 7, data 22, en 1}.
  - Response: wb_rd_enable=2'b10, lane1 data=22, lane0 data=0 and addr=0.
- Flush priority:
  - Stimulus: occupancy=2; flush=1 together with in_valid=1 and out_ready=0.
  - Response: next cycle occupancy=0, out_valid=0, in_ready=1, all wb_*=0; the offered beat never appears.
- Async reset mid-stream:
  - Stimulus: occupancy=1 and out_valid=1; rst driven low between clock edges.
  - Response: out_valid=0, wb_rd_enable=0 and occupancy=0 before the next rising edge.
